// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: holds the fetch PC, issues one pack request at a time to instruction memory,
// queues returned 4-instruction packs for decode and drops responses made stale by a redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  output logic         mem_req,
  input  logic         mem_ready,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_inst_value,
  input  logic         mem_valid,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_pc,
  output logic [127:0] out_inst,
  output logic [3:0]   out_mask
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FQ_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;
  state_t state;
  logic ready_q;
  logic [31:0] pc;
  logic [31:0] base;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [31:0] q_pc [FQ_DEPTH];
  logic [127:0] q_inst [FQ_DEPTH];
  logic [3:0] q_mask [FQ_DEPTH];
  logic edge_hit, push, pop;
  assign base = {pc[31:4], 4'b0};
  // a level-high mem_ready only counts once: the response is its rising edge
  assign edge_hit = mem_ready & ~ready_q & (state == WAIT || state == DRAIN);
  assign push = edge_hit & (state == WAIT) & mem_valid & ~redirect_valid;
  assign pop = out_valid & out_ready & ~redirect_valid;
  assign mem_req = (state == WAIT) & ~mem_ready;
  assign out_valid = count != '0;
  assign out_pc = out_valid ? q_pc[rd_ptr] : '0;
  assign out_inst = out_valid ? q_inst[rd_ptr] : '0;
  assign out_mask = out_valid ? q_mask[rd_ptr] : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      ready_q <= 1'b0;
      mem_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      ready_q <= mem_ready;
      if (redirect_valid) begin
        pc <= redirect_pc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        state <= (state == WAIT && !edge_hit) ? DRAIN : IDLE;
      end else begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        case (state)
          IDLE: if (count < DEPTH) begin
            state <= WAIT;
            mem_addr <= {4'b0, pc[31:4]};
          end
          WAIT: if (edge_hit) begin
            state <= mem_valid ? IDLE : HALT;
            pc <= mem_valid ? base + 32'd16 : pc;
          end
          DRAIN: if (edge_hit) state <= IDLE;
          default: ;
        endcase
      end
    end
  always_ff @(posedge clock)
    if (push) begin
      q_pc[wr_ptr] <= base;
      q_inst[wr_ptr] <= mem_inst_value;
      q_mask[wr_ptr] <= 4'b1111 << pc[3:2];
    end
endmodule
